ysyx_22040000_axil_sram: RTL and testbench

//  AXI4-Lite memory responder: the target end of the core's fetch/load/store path.

---
 rtl/ysyx_22040000_axil_pkg.sv | 23 ++
 rtl/ysyx_22040000_lfsr8.sv | 21 ++
 rtl/ysyx_22040000_axil_sram.sv | 204 ++++++++++++++++++++
 tb/tb_ysyx_22040000_axil_sram.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040000_axil_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder.
//   RESP_OKAY / RESP_SLVERR : AXI response codes driven on rresp / bresp
//   axil_state_e            : responder state machine encoding
//   axil_prio_e             : which side wins when a read and a pending write collide
package ysyx_22040000_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } axil_state_e;

  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } axil_prio_e;

endpackage

// File: rtl/ysyx_22040000_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, used to draw
// pseudo-random response latencies.
//   clk, rst : clock, asynchronous active-low reset (reloads SEED)
//   en       : advance one step
//   q        : current LFSR state
module ysyx_22040000_lfsr8 #(
  parameter logic [7:0] SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  // Taps for x^8, x^6, x^5, x^4 on a left-shifting register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= SEED;
    else if (en) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/ysyx_22040000_axil_sram.sv
// AXI4-Lite memory responder: serves one transaction at a time from a word
// array with a fixed (RD_LAT / WR_LAT) or pseudo-random response delay.
// Build option: define SRAM_RAND_DELAY_EN to draw each wait from an 8-bit
// LFSR (1..8 cycles) instead of the fixed latency parameters.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   araddr/arvalid/arready            read address channel
//   rdata/rresp/rvalid/rready         read data channel
//   awaddr/awvalid/awready            write address channel
//   wdata/wstrb/wvalid/wready         write data channel
//   bresp/bvalid/bready               write response channel
module ysyx_22040000_axil_sram
  import ysyx_22040000_axil_pkg::*;
#(
  parameter int              DWIDTH     = 32,
  parameter int              AWIDTH     = 32,
  parameter int              MEM_AWIDTH = 10,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int              RD_LAT     = 2,
  parameter int              WR_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AWIDTH-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DWIDTH-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [AWIDTH-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DWIDTH-1:0]     wdata,
  input  logic [DWIDTH/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int SW    = DWIDTH / 8;
  localparam int DEPTH = 1 << MEM_AWIDTH;
  localparam int CW    = 16;
  // One extra bit so the end-of-window bound cannot wrap.
  localparam logic [AWIDTH:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [AWIDTH:0] ADDR_HI = ADDR_LO + ((AWIDTH+1)'(1) << (MEM_AWIDTH + 2));

  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    logic [AWIDTH:0] w;
    w = {1'b0, a};
    return (w >= ADDR_LO) && (w < ADDR_HI);
  endfunction

  logic [DWIDTH-1:0]     mem [DEPTH];

  axil_state_e           state;
  axil_prio_e            prio;
  logic                  live;
  logic                  aw_got, w_got;
  logic [AWIDTH-1:0]     aw_addr, ar_addr;
  logic [DWIDTH-1:0]     w_data;
  logic [SW-1:0]         w_strb;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         lat_load;

  logic                  is_idle, wr_pend;
  logic                  ar_hs, aw_hs, w_hs;
  logic                  start_rd, start_wr, wait_entry;
  logic                  ar_ok, aw_ok;
  logic [MEM_AWIDTH-1:0] ar_idx, aw_idx;

  assign is_idle = (state == IDLE);
  assign wr_pend = aw_got & w_got;

  // live is a flop cleared by reset, so the ready outputs stay low for the
  // whole reset window without mixing the async reset into datapath logic.
  assign arready = live & is_idle & !(wr_pend & (prio == PRIO_WRITE));
  assign awready = live & is_idle & !aw_got;
  assign wready  = live & is_idle & !w_got;

  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid  & wready;

  // arready already encodes the priority, so a read handshake always wins
  // the cycle it happens in; otherwise a pending write goes.
  assign start_rd   = ar_hs;
  assign start_wr   = is_idle & wr_pend & !ar_hs;
  assign wait_entry = start_rd | start_wr;

  assign ar_ok  = addr_ok(ar_addr);
  assign aw_ok  = addr_ok(aw_addr);
  assign ar_idx = ar_addr[2 +: MEM_AWIDTH];
  assign aw_idx = aw_addr[2 +: MEM_AWIDTH];

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  ysyx_22040000_lfsr8 #(.SEED(8'h5A)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (wait_entry),
    .q   (lfsr_q)
  );

  // Counter value 0..7 gives a wait of 1..8 cycles.
  assign lat_load = {{(CW-3){1'b0}}, lfsr_q[2:0]};
`else
  assign lat_load = start_rd ? CW'(RD_LAT - 1) : CW'(WR_LAT - 1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      prio    <= PRIO_WRITE;
      live    <= 1'b0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      cnt     <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      live <= 1'b1;
      if (aw_hs) begin
        aw_got  <= 1'b1;
        aw_addr <= awaddr;
      end
      if (w_hs) begin
        w_got  <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (ar_hs) ar_addr <= araddr;

      case (state)
        IDLE: begin
          if (start_rd) begin
            state <= RD_WAIT;
            prio  <= PRIO_WRITE;
            cnt   <= lat_load;
          end else if (start_wr) begin
            state <= WR_WAIT;
            prio  <= PRIO_READ;
            cnt   <= lat_load;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            state  <= RD_RESP;
            rvalid <= 1'b1;
            rdata  <= ar_ok ? mem[ar_idx] : '0;
            rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            state  <= WR_RESP;
            bvalid <= 1'b1;
            bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RESP: begin
          if (rready) begin
            state  <= IDLE;
            rvalid <= 1'b0;
          end
        end
        WR_RESP: begin
          if (bready) begin
            state  <= IDLE;
            bvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset. Reset forces state to IDLE asynchronously, so an
  // abandoned write can never reach its commit cycle.
  always_ff @(posedge clk) begin
    if (state == WR_WAIT && cnt == '0 && aw_ok) begin
      for (int b = 0; b < SW; b++) begin
        if (w_strb[b]) mem[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040000_axil_sram.sv
module tb_ysyx_22040000_axil_sram;
  import ysyx_22040000_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, awready, wready, rvalid, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int checks = 0;
  int errors = 0;
  logic ord[$];   // completed beats in order: 0 = read, 1 = write

  always #5 clk = ~clk;

  ysyx_22040000_axil_sram dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always @(posedge clk) begin
    if (rst && rvalid && rready) ord.push_back(1'b0);
    if (rst && bvalid && bready) ord.push_back(1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Full write transaction; bounded waits report a FAIL on expiry.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [1:0] r);
    int n = 0;
    logic aw_acc, w_acc;
    r = 2'bxx;
    @(negedge clk);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 1;
    while ((awvalid || wvalid) && n < 100) begin
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      @(negedge clk);
      if (aw_acc) awvalid = 0;
      if (w_acc)  wvalid  = 0;
      n++;
    end
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!bvalid) begin
      errors++;
      $display("FAIL wr_timeout addr=%h got bvalid=%b want 1", a, bvalid);
      awvalid = 0; wvalid = 0; bready = 0;
      return;
    end
    r = bresp;
    @(negedge clk);
    bready = 0;
  endtask

  // Full read transaction; lat = cycles from AR handshake edge to rvalid.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] r, output int lat);
    int n = 0;
    d = 'x; r = 2'bxx; lat = 0;
    @(negedge clk);
    arvalid = 1; araddr = a; rready = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!arready) begin
      errors++;
      $display("FAIL rd_ar_timeout addr=%h got arready=%b want 1", a, arready);
      arvalid = 0;
      return;
    end
    @(negedge clk);
    arvalid = 0;
    while (!rvalid && lat < 100) begin lat++; @(negedge clk); end
    checks++;
    if (!rvalid) begin
      errors++;
      $display("FAIL rd_timeout addr=%h got rvalid=%b want 1", a, rvalid);
      return;
    end
    d = rdata; r = rresp;
    rready = 1;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic test_reset();
    logic [1:0] r;
    @(negedge clk);
    checks++;
    if (rvalid !== 0 || bvalid !== 0 || rdata !== 0 || rresp !== 0 || bresp !== 0) begin
      errors++;
      $display("FAIL reset_outputs got rv=%b bv=%b rdata=%h rresp=%b bresp=%b want all 0",
               rvalid, bvalid, rdata, rresp, bresp);
    end
    checks++;
    if (arready !== 0 || awready !== 0 || wready !== 0) begin
      errors++;
      $display("FAIL reset_ready got ar=%b aw=%b w=%b want 0", arready, awready, wready);
    end
    @(negedge clk);
    rst = 1;
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, r);
    checks++;
    if (r !== RESP_OKAY) begin errors++; $display("FAIL preload_bresp got %b want 00", r); end
  endtask

  task automatic test_read_latency();
    logic [31:0] d; logic [1:0] r; int lat;
    do_read(32'h8000_0000, d, r, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_word0 got %h want deadbeef", d); end
    checks++;
    if (r !== RESP_OKAY) begin errors++; $display("FAIL rd_word0_resp got %b want 00", r); end
    @(negedge clk);
    checks++;
    if (rvalid !== 0) begin errors++; $display("FAIL rvalid_drop got %b want 0", rvalid); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; int lat, beats;
    logic [1:0] seen;
    do_write(32'h8000_0004, 32'h1122_3344, 4'hF, r);
    @(negedge clk);
    wvalid = 1; wdata = 32'h0000_AB00; wstrb = 4'b0010; bready = 1;
    checks++;
    if (wready !== 1) begin errors++; $display("FAIL w_ready_idle got %b want 1", wready); end
    @(negedge clk);
    wvalid = 0;
    checks++;
    if (wready !== 0 || awready !== 1) begin
      errors++;
      $display("FAIL w_captured got wready=%b awready=%b want 0 1", wready, awready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (wready !== 0 || bvalid !== 0) begin
        errors++;
        $display("FAIL w_hold got wready=%b bvalid=%b want 0 0", wready, bvalid);
      end
    end
    @(negedge clk);
    awvalid = 1; awaddr = 32'h8000_0004;
    checks++;
    if (awready !== 1) begin errors++; $display("FAIL aw_ready got %b want 1", awready); end
    @(negedge clk);
    awvalid = 0;
    beats = 0; seen = 2'bxx;
    for (int i = 0; i < 12; i++) begin
      if (bvalid && bready) begin beats++; seen = bresp; end
      @(negedge clk);
    end
    bready = 0;
    checks++;
    if (beats !== 1) begin errors++; $display("FAIL wr_beats got %0d want 1", beats); end
    checks++;
    if (seen !== RESP_OKAY) begin errors++; $display("FAIL wr_bresp got %b want 00", seen); end
    do_read(32'h8000_0004, d, r, lat);
    checks++;
    if (d !== 32'h1122_AB44) begin errors++; $display("FAIL strb_merge got %h want 1122ab44", d); end
  endtask

  // The write is captured one cycle ahead of the read address, so the read
  // and the pending write are both eligible in the same IDLE cycle.
  task automatic test_arbitration();
    int n;
    logic [31:0] d; logic [1:0] r; int lat;
    ord.delete();
    rready = 1; bready = 1;
    @(negedge clk);
    awvalid = 1; awaddr = 32'h8000_0008; wvalid = 1; wdata = 32'hA5A5_0001; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 1; araddr = 32'h8000_0000;
    checks++;
    if (arready !== 0) begin errors++; $display("FAIL arb_write_first got arready=%b want 0", arready); end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (ord.size() < 1 && n < 50) begin @(negedge clk); n++; end
    awvalid = 1; awaddr = 32'h8000_000C; wvalid = 1; wdata = 32'hA5A5_0002; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 1; araddr = 32'h8000_0000;
    checks++;
    if (arready !== 1) begin errors++; $display("FAIL arb_read_second got arready=%b want 1", arready); end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (ord.size() < 3 && n < 50) begin @(negedge clk); n++; end
    rready = 0; bready = 0;
    checks++;
    if (ord.size() !== 3 || ord[0] !== 1'b1 || ord[1] !== 1'b0 || ord[2] !== 1'b1) begin
      errors++;
      $display("FAIL arb_order got %0d beats %p want W R W", ord.size(), ord);
    end
    do_read(32'h8000_000C, d, r, lat);
    checks++;
    if (d !== 32'hA5A5_0002) begin errors++; $display("FAIL arb_word3 got %h want a5a50002", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat;
    do_read(32'h0000_0000, d, r, lat);
    checks++;
    if (r !== RESP_SLVERR || d !== 32'h0) begin
      errors++;
      $display("FAIL oor_read got resp=%b data=%h want 10 00000000", r, d);
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL oor_rd_latency got %0d want 2", lat); end
    do_write(32'h9000_0000, 32'hFFFF_FFFF, 4'hF, r);
    checks++;
    if (r !== RESP_SLVERR) begin errors++; $display("FAIL oor_bresp got %b want 10", r); end
    // 0x90000000 aliases word 0 in the index bits; word 0 must be intact.
    do_read(32'h8000_0000, d, r, lat);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_no_write got %h want deadbeef", d); end
  endtask

  task automatic test_backpressure();
    int n = 0, beats = 0;
    @(negedge clk);
    arvalid = 1; araddr = 32'h8000_0004; rready = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1 || rdata !== 32'h1122_AB44 || arready !== 0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rv=%b rdata=%h arready=%b want 1 1122ab44 0",
                 i, rvalid, rdata, arready);
      end
      @(negedge clk);
    end
    rready = 1;
    for (int i = 0; i < 4; i++) begin
      if (rvalid && rready) beats++;
      @(negedge clk);
    end
    rready = 0;
    checks++;
    if (beats !== 1) begin errors++; $display("FAIL bp_beats got %0d want 1", beats); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h8000_0014, 32'h55AA_55AA, 4'hF, r);
    @(negedge clk);
    awvalid = 1; awaddr = 32'h8000_0014; wvalid = 1; wdata = 32'h0; wstrb = 4'hF; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);   // now in WR_WAIT, one cycle from commit
    rst = 0;
    #1;
    checks++;
    if (bvalid !== 0 || arready !== 0 || awready !== 0 || wready !== 0 || rvalid !== 0) begin
      errors++;
      $display("FAIL rst_mid got bv=%b ar=%b aw=%b w=%b rv=%b want 0",
               bvalid, arready, awready, wready, rvalid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1; bready = 0;
    do_read(32'h8000_0014, d, r, lat);
    checks++;
    if (d !== 32'h55AA_55AA || r !== RESP_OKAY) begin
      errors++;
      $display("FAIL rst_no_write got %h resp=%b want 55aa55aa 00", d, r);
    end
    do_write(32'h8000_0018, 32'h0BAD_F00D, 4'hF, r);
    checks++;
    if (r !== RESP_OKAY) begin errors++; $display("FAIL rst_next_ok got %b want 00", r); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_w_before_aw();
    test_arbitration();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
